pipelined_add_sub: RTL and testbench
====================================

Name: pipelined_add_sub

Overview:
- Parametrised, pipelined integer add/subtract unit. Successor to the team's fixed 32-bit ripple-carry adder.
- Operand width is split into SEGS equal segments. Each pipeline stage resolves one segment, passing the carry stage-to-stage, so the critical path is one segment-wide ripple.
- Adds ADD/SUB/ADC/SBC modes, status flags and a valid/ready handshake with backpressure on both sides.
- Sits between the operand-select logic and the ALU result mux.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of SEGS.
- SEGS, 4, number of segments and pipeline stages (1..WIDTH); SEG_W = WIDTH/SEGS.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/op presented this cycle
- in_ready  out  1  unit accepts operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  2  00 ADD (a+b), 01 SUB (a-b), 10 ADC (a+b+cin), 11 SBC (a-b-!cin)
- cin  in  1  carry input, used by ADC/SBC only
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- r  out  WIDTH  result
- cout  out  1  carry out of MSB; for SUB/SBC 1 = no borrow
- ovf  out  1  signed two's-complement overflow
- zero  out  1  r == 0
- neg  out  1  r[WIDTH-1]

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0. out_valid=0, r=0, cout=0, ovf=0, zero=0, neg=0. in_ready=1 from the first cycle after release.
- Operand conditioning at entry: b_eff = b for ADD/ADC, ~b for SUB/SBC. c0 = 0 for ADD, 1 for SUB, cin for ADC, cin for SBC (SBC = a + ~b + cin).
- Accept when in_valid && in_ready. Stage 1 latches segment 0 sum and carry, plus the remaining raw segments of a and b_eff. Stage k adds segment k-1 with the carry from stage k-1. Already-computed low segments are carried forward unchanged (operand skew).
- Each stage holds a valid bit. A stage loads when it is empty or its downstream stage is moving. stage_ready[k] = !valid[k] || stage_ready[k+1]; last stage uses out_ready. in_ready = stage_ready[1], combinational, with no extra bubble.
- Latency: exactly SEGS cycles from accept to out_valid when out_ready=1 throughout. Throughput: one result per cycle.
- Backpressure: when out_valid && !out_ready, r and all flags hold stable. The pipeline fills, then in_ready drops. No result is lost or duplicated, and results leave in accept order.
- Flags come from the final stage. cout = carry out of bit WIDTH-1. ovf = carry into MSB XOR carry out of MSB. zero and neg are taken from the full r.
- Wrap-around: results are modulo 2^WIDTH. No saturation.
- in_valid while !in_ready: inputs are ignored; the producer must hold them.
- Reset mid-operation clears every in-flight entry immediately. No partial output is produced.
- SEGS=1 degenerates to a single registered adder, latency 1.

Decomposition:
- Shared package alu_pkg: op encodings OP_ADD/OP_SUB/OP_ADC/OP_SBC.
- One sub-module, seg_adder: SEG_W-bit combinational ripple adder with cin/cout and MSB carry-in output. Instantiated SEGS times via generate.

Test Plan:
- WIDTH=32, SEGS=4, ADD a=0xFFFFFFFF, b=0x00000001, out_ready=1 -> out_valid after 4 cycles, r=0, cout=1, zero=1, ovf=0. Verifies carry crossing all segments.
- SUB a=0x80000000, b=1 -> r=0x7FFFFFFF, ovf=1, cout=1, neg=0. Then SUB a=0, b=1 -> r=0xFFFFFFFF, cout=0, neg=1.
- ADC a=5, b=7, cin=1 -> r=13. SBC a=5, b=7, cin=0 -> r=0xFFFFFFFD, cout=0.
- Back-to-back stream of 16 random ADDs, out_ready=1 -> in_ready stays 1, results every cycle, in order, matching the reference model.
- out_ready=0 for 8 cycles while streaming -> in_ready drops after 4 accepts plus the held output. r is stable during the stall. On release, all results drain in order with no loss or duplication.
- rst_n pulsed low with 3 entries in flight -> out_valid=0 and r=0 immediately. No stale result appears after release. Repeat the first scenario with SEGS=1 and SEGS=8 -> latency 1 and 8 respectively.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings for the add/subtract datapath.
package alu_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_ADC = 2'b10,
      OP_SBC = 2'b11
   } op_e;

endpackage

// File: rtl/seg_adder.sv
// Combinational ripple adder for one segment; also exposes the carry into its MSB
// so the final stage can form the signed-overflow flag.
module seg_adder #(
   parameter int SEG_W = 8
) (
   input  logic [SEG_W-1:0] a,
   input  logic [SEG_W-1:0] b,
   input  logic             cin,
   output logic [SEG_W-1:0] s,
   output logic             cout,
   output logic             cmsb
);

   logic [SEG_W:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = cin;
      for (int i = 0; i < SEG_W; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign cout = c[SEG_W];
   assign cmsb = c[SEG_W-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// Segmented, pipelined add/subtract unit: one SEG_W-bit segment resolved per stage,
// carry handed stage to stage, valid/ready handshake with backpressure.
module pipelined_add_sub
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SEGS  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] r,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             neg
);

   localparam int SEG_W = WIDTH / SEGS;

   logic [WIDTH-1:0] b_eff;
   logic             c0;

   // stage registers: acc_p holds finished low segments plus still-raw high segments of a
   logic [SEGS:1]    vld_p;
   logic [WIDTH-1:0] acc_p [1:SEGS];
   logic [WIDTH-1:0] bop_p [1:SEGS];
   logic [SEGS:1]    cy_p;
   logic             cmsb_p;

   logic [SEGS+1:1]  rdy;
   logic [WIDTH-1:0] acc_i [1:SEGS];
   logic [WIDTH-1:0] bop_i [1:SEGS];
   logic [SEGS:1]    cy_i;
   logic [SEGS:1]    vld_i;
   logic [SEG_W-1:0] sa_s  [1:SEGS];
   logic [SEG_W-1:0] sb_s  [1:SEGS];
   logic [SEG_W-1:0] sum_s [1:SEGS];
   logic             co_s  [1:SEGS];
   logic             cm_s  [1:SEGS];

   // SBC is a + ~b + cin, so cin=0 means "borrow in"
   always_comb begin
      b_eff = b;
      c0    = 1'b0;
      case (op_e'(op))
         OP_ADD: c0 = 1'b0;
         OP_SUB: begin b_eff = ~b; c0 = 1'b1; end
         OP_ADC: c0 = cin;
         OP_SBC: begin b_eff = ~b; c0 = cin; end
         default: c0 = 1'b0;
      endcase
   end

   always_comb begin
      rdy[SEGS+1] = out_ready;
      for (int k = SEGS; k >= 1; k--) begin
         rdy[k] = !vld_p[k] || rdy[k+1];
      end
   end

   always_comb begin
      acc_i[1] = a;
      bop_i[1] = b_eff;
      cy_i[1]  = c0;
      vld_i[1] = in_valid;
      for (int k = 2; k <= SEGS; k++) begin
         acc_i[k] = acc_p[k-1];
         bop_i[k] = bop_p[k-1];
         cy_i[k]  = cy_p[k-1];
         vld_i[k] = vld_p[k-1];
      end
      for (int k = 1; k <= SEGS; k++) begin
         sa_s[k] = acc_i[k][(k-1)*SEG_W +: SEG_W];
         sb_s[k] = bop_i[k][(k-1)*SEG_W +: SEG_W];
      end
   end

   for (genvar g = 1; g <= SEGS; g++) begin : g_seg
      seg_adder #(.SEG_W(SEG_W)) u_add (
         .a    (sa_s[g]),
         .b    (sb_s[g]),
         .cin  (cy_i[g]),
         .s    (sum_s[g]),
         .cout (co_s[g]),
         .cmsb (cm_s[g])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p <= '0;
      end else begin
         for (int k = 1; k <= SEGS; k++) begin
            if (rdy[k]) vld_p[k] <= vld_i[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 1; k <= SEGS; k++) begin
         if (rdy[k] && vld_i[k]) begin
            acc_p[k]                           <= acc_i[k];
            acc_p[k][(k-1)*SEG_W +: SEG_W]     <= sum_s[k];
            bop_p[k]                           <= bop_i[k];
            cy_p[k]                            <= co_s[k];
         end
      end
      if (rdy[SEGS] && vld_i[SEGS]) cmsb_p <= cm_s[SEGS];
   end

   // outputs are masked by valid so an empty or freshly reset pipe presents all zeros
   assign in_ready  = rdy[1];
   assign out_valid = vld_p[SEGS];
   assign r         = out_valid ? acc_p[SEGS] : '0;
   assign cout      = out_valid & cy_p[SEGS];
   assign ovf       = out_valid & (cy_p[SEGS] ^ cmsb_p);
   assign zero      = out_valid & (acc_p[SEGS] == '0);
   assign neg       = out_valid & acc_p[SEGS][WIDTH-1];

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Scoreboard bench for pipelined_add_sub: driver pushes reference results, monitor pops
// and compares on every output handshake; extra instances cover SEGS=1 and SEGS=8.
module tb_pipelined_add_sub;
   import alu_pkg::*;

   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -SMAX - 1;

   typedef struct {
      logic [31:0] r;
      logic        c;
      logic        v;
      bit          lat;
      int          t;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic [1:0]  op;
   logic        cin;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] r;
   logic        cout, ovf, zero, neg;

   logic        iv1, ir1, ov1, c1, v1, z1, n1;
   logic [31:0] r1;
   logic        iv8, ir8, ov8, c8, v8, z8, n8;
   logic [31:0] r8;
   logic        ordy_x = 1'b1;

   exp_t        sbq[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pipelined_add_sub #(.WIDTH(32), .SEGS(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .r(r), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
   );

   pipelined_add_sub #(.WIDTH(32), .SEGS(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
      .a(a), .b(b), .op(op), .cin(cin), .out_valid(ov1), .out_ready(ordy_x),
      .r(r1), .cout(c1), .ovf(v1), .zero(z1), .neg(n1)
   );

   pipelined_add_sub #(.WIDTH(32), .SEGS(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
      .a(a), .b(b), .op(op), .cin(cin), .out_valid(ov8), .out_ready(ordy_x),
      .r(r8), .cout(c8), .ovf(v8), .zero(z8), .neg(n8)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // reference: plain wide arithmetic, overflow = true signed result outside 32-bit range
   function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                  input logic [1:0] mop, input logic mc);
      exp_t   e;
      longint sa, sb, ua, ub, st, k;
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      ua = longint'({32'd0, ma});
      ub = longint'({32'd0, mb});
      e.lat = 1'b0;
      e.t   = 0;
      if (mop == 2'b00 || mop == 2'b10) begin
         k   = (mop == 2'b10 && mc) ? 64'sd1 : 64'sd0;
         st  = sa + sb + k;
         e.r = 32'(ua + ub + k);
         e.c = (ua + ub + k) >= 64'sd4294967296;
      end else begin
         k   = (mop == 2'b11 && !mc) ? 64'sd1 : 64'sd0;
         st  = sa - sb - k;
         e.r = 32'(ua - ub - k);
         e.c = ua >= (ub + k);
      end
      e.v = (st > SMAX) || (st < SMIN);
      return e;
   endfunction

   // monitor: compare on each output handshake, and check stability while stalled
   logic [31:0] held_r;
   logic [3:0]  held_f;
   bit          held = 1'b0;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            held = 1'b0;
         end else begin
            if (out_valid && !out_ready) begin
               if (held) begin
                  chk("stall_r", r, held_r);
                  chk("stall_flags", 32'({cout, ovf, zero, neg}), 32'(held_f));
               end
               held   = 1'b1;
               held_r = r;
               held_f = {cout, ovf, zero, neg};
            end else begin
               held = 1'b0;
            end
            if (out_valid && out_ready) begin
               if (sbq.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_output actual r=%h required no output", r);
               end else begin
                  e = sbq.pop_front();
                  chk("r", r, e.r);
                  chk("cout", 32'(cout), 32'(e.c));
                  chk("ovf", 32'(ovf), 32'(e.v));
                  chk("zero", 32'(zero), 32'(e.r == 32'd0));
                  chk("neg", 32'(neg), 32'(e.r[31]));
                  if (e.lat) chk("latency", 32'(cyc - e.t), 32'd4);
               end
            end
         end
      end
   end

   task automatic drive(input logic [31:0] ta, input logic [31:0] tb, input logic [1:0] top,
                        input logic tc, input bit dir, input exp_t de, output bit waited);
      int   w = 0;
      exp_t e;
      in_valid = 1'b1;
      a = ta; b = tb; op = top; cin = tc;
      #1;
      while (!in_ready && w < 100) begin
         @(negedge clk);
         #1;
         w++;
      end
      waited = (w != 0);
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout actual in_ready=0 required 1");
      end else begin
         e   = dir ? de : model(ta, tb, top, tc);
         e.t = cyc;
         sbq.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic drain();
      int w = 0;
      in_valid = 1'b0;
      while (sbq.size() != 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      @(negedge clk);
      chk("drain_left", 32'(sbq.size()), 32'd0);
   endtask

   task automatic directed(input logic [31:0] ta, input logic [31:0] tb, input logic [1:0] top,
                           input logic tc, input logic [31:0] er, input logic ec, input logic ev);
      exp_t d;
      bit   wt;
      d.r = er; d.c = ec; d.v = ev; d.lat = 1'b1; d.t = 0;
      drive(ta, tb, top, tc, 1'b1, d, wt);
      drain();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t        dz;
      bit          wt, pend;
      int          cnt, l1, l8, t0;
      logic [31:0] pick [5];
      dz = '{r: 32'd0, c: 1'b0, v: 1'b0, lat: 1'b0, t: 0};
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0; cin = 1'b0;
      out_ready = 1'b1; iv1 = 1'b0; iv8 = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_r", r, 32'd0);
      chk("rst_flags", 32'({cout, ovf, zero, neg}), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);

      directed(32'hFFFF_FFFF, 32'h1, OP_ADD, 1'b0, 32'h0, 1'b1, 1'b0);
      directed(32'h8000_0000, 32'h1, OP_SUB, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
      directed(32'h0, 32'h1, OP_SUB, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
      directed(32'd5, 32'd7, OP_ADC, 1'b1, 32'd13, 1'b0, 1'b0);
      directed(32'd5, 32'd7, OP_SBC, 1'b0, 32'hFFFF_FFFD, 1'b0, 1'b0);
      directed(32'h7FFF_FFFF, 32'h1, OP_ADD, 1'b0, 32'h8000_0000, 1'b0, 1'b1);

      for (int i = 0; i < 16; i++) begin
         drive($urandom, $urandom, OP_ADD, 1'b0, 1'b0, dz, wt);
         checks++;
         if (wt) begin
            failures++;
            $display("FAIL stream_in_ready actual stalled required no stall at item %0d", i);
         end
      end
      drain();

      out_ready = 1'b0;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3)); cin = 1'($urandom);
         #1;
         if (in_ready) begin
            sbq.push_back(model(a, b, op, cin));
            cnt++;
         end
         @(negedge clk);
      end
      #1;
      chk("stall_accepts", 32'(cnt), 32'd4);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain();

      pick[0] = 32'h0; pick[1] = 32'hFFFF_FFFF; pick[2] = 32'h8000_0000; pick[3] = 32'h7FFF_FFFF;
      pend = 1'b0;
      for (int i = 0; i < 300; i++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         if (!pend) begin
            in_valid = ($urandom_range(0, 2) != 0);
            pick[4] = $urandom;
            a  = pick[$urandom_range(0, 4)];
            pick[4] = $urandom;
            b  = pick[$urandom_range(0, 4)];
            op = 2'($urandom_range(0, 3));
            cin = 1'($urandom);
         end
         #1;
         if (in_valid && in_ready) begin
            sbq.push_back(model(a, b, op, cin));
            pend = 1'b0;
         end else begin
            pend = in_valid;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain();

      for (int i = 0; i < 3; i++) drive($urandom, $urandom, OP_SUB, 1'b0, 1'b0, dz, wt);
      rst_n = 1'b0;
      sbq.delete();
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_r", r, 32'd0);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      #1;
      chk("postrst_out_valid", 32'(out_valid), 32'd0);

      a = 32'hFFFF_FFFF; b = 32'h1; op = OP_ADD; cin = 1'b0;
      iv1 = 1'b1; iv8 = 1'b1;
      #1;
      chk("seg1_in_ready", 32'(ir1), 32'd1);
      chk("seg8_in_ready", 32'(ir8), 32'd1);
      t0 = cyc;
      @(negedge clk);
      iv1 = 1'b0; iv8 = 1'b0;
      l1 = -1; l8 = -1;
      for (int w = 0; w < 20; w++) begin
         #2;
         if (ov1 && l1 < 0) begin
            l1 = cyc - t0;
            chk("seg1_r", r1, 32'h0);
            chk("seg1_flags", 32'({c1, v1, z1, n1}), 32'b1010);
         end
         if (ov8 && l8 < 0) begin
            l8 = cyc - t0;
            chk("seg8_r", r8, 32'h0);
            chk("seg8_flags", 32'({c8, v8, z8, n8}), 32'b1010);
         end
         @(negedge clk);
      end
      chk("seg1_latency", 32'(l1), 32'd1);
      chk("seg8_latency", 32'(l8), 32'd8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
